// File: rtl/mdu_seq_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; DATA_W+2 cycles start->done, stalls EX while busy.
// Define MDU_EARLY_OUT_EN to let multiplies leave RUN once the remaining multiplier bits are zero.
module mdu_seq_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam int CW = $clog2(DATA_W);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W - 1);

`ifdef MDU_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic                is_div_q, neg_q, neg_r_q, done_q;
  logic [2*DATA_W-1:0] acc_q, a_q;
  logic [DATA_W-1:0]   b_q, hi_q, lo_q;

  logic                is_mul, is_dv, sgn, sa, sb, div0, run_exit;
  logic [DATA_W-1:0]   a_abs, b_abs;
  logic [2*DATA_W-1:0] acc_step, prod;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W-1:0]   diff, rem_nx, quot_nx, res_hi, res_lo;
  logic                ge;

  assign is_mul = (funct == F_MULT) || (funct == F_MULTU);
  assign is_dv  = (funct == F_DIV)  || (funct == F_DIVU);
  assign sgn    = (funct == F_MULT) || (funct == F_DIV);
  assign sa     = sgn & op_a[DATA_W-1];
  assign sb     = sgn & op_b[DATA_W-1];
  assign a_abs  = sa ? -op_a : op_a;
  assign b_abs  = sb ? -op_b : op_b;
  assign div0   = (op_b == '0);

  // Multiply: a_q holds the multiplicand pre-shifted to the current bit weight.
  assign acc_step = acc_q + (b_q[0] ? a_q : '0);

  // Restore-divide: remainder lives in acc_q low half, dividend/quotient share b_q.
  assign rem_sh  = {acc_q[DATA_W-1:0], b_q[DATA_W-1]};
  assign ge      = rem_sh >= {1'b0, a_q[DATA_W-1:0]};
  assign diff    = rem_sh[DATA_W-1:0] - a_q[DATA_W-1:0];
  assign rem_nx  = ge ? diff : rem_sh[DATA_W-1:0];
  assign quot_nx = {b_q[DATA_W-2:0], ge};

  assign run_exit = (cnt_q == '0) || (EARLY && !is_div_q && (b_q[DATA_W-1:1] == '0));

  assign prod   = neg_q ? -acc_q : acc_q;
  assign res_hi = is_div_q ? (neg_r_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0]) : prod[2*DATA_W-1:DATA_W];
  assign res_lo = is_div_q ? (neg_q ? -b_q : b_q) : prod[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      neg_r_q  <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && (is_mul || is_dv)) begin
              is_div_q <= is_dv;
              cnt_q    <= CNT_LAST;
              acc_q    <= '0;
              a_q      <= {{DATA_W{1'b0}}, is_dv ? b_abs : a_abs};
              // Divide by zero keeps the raw dividend so it falls out as the remainder.
              if (is_dv && div0) begin
                b_q     <= op_a;
                neg_q   <= 1'b0;
                neg_r_q <= 1'b0;
              end else begin
                b_q     <= is_dv ? a_abs : b_abs;
                neg_q   <= sa ^ sb;
                neg_r_q <= is_dv & sa;
              end
              state_q <= (EARLY && is_mul && (b_abs == '0)) ? S_FIX : S_RUN;
            end else if (start && funct == F_MTHI) begin
              hi_q <= op_a;
            end else if (start && funct == F_MTLO) begin
              lo_q <= op_a;
            end
          end
          S_RUN: begin
            if (is_div_q) begin
              acc_q <= {{DATA_W{1'b0}}, rem_nx};
              b_q   <= quot_nx;
            end else begin
              acc_q <= acc_step;
              a_q   <= a_q << 1;
              b_q   <= b_q >> 1;
            end
            cnt_q <= cnt_q - CW'(1);
            if (run_exit) state_q <= S_FIX;
          end
          S_FIX: begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign stall = (state_q == S_IDLE && start && (is_mul || is_dv) && !flush) ||
                 (state_q == S_RUN) || (state_q == S_FIX);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed-vector bench for mdu_seq_ctrl (DATA_W=32).
module tb_mdu_seq_ctrl;

  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  logic        clk, rst_n, start, flush, stall, done;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b, hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  mdu_seq_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected multiply latency from the magnitude of the multiplier.
  function automatic int mul_lat(input logic [31:0] babs);
`ifdef MDU_EARLY_OUT_EN
    int h;
    h = -1;
    for (int i = 0; i < 32; i++) if (babs[i]) h = i;
    return (h < 0) ? 2 : h + 3;
`else
    return 34;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    int cyc;
    bit stall_ok;
    start = 1'b1; funct = f; op_a = a; op_b = b;
    #1;
    cyc = 0;
    stall_ok = 1'b1;
    while (done !== 1'b1 && cyc < 100) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      tick();
      cyc++;
    end
    chk({tag, " stall_busy"}, 64'(stall_ok), 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    chk({tag, " stall_in_done"}, 64'(stall), 64'd0);
    // start still held across the DONE edge; it must not relaunch.
    tick();
    start = 1'b0;
    #1;
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
    chk({tag, " idle_after"}, 64'(stall), 64'd0);
    last_hi = eh;
    last_lo = el;
  endtask

  task automatic watch_no_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done !== 1'b0) seen = 1'b1;
    end
    chk({tag, " no_done"}, 64'(seen), 64'd0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct = 6'h0; op_a = '0; op_b = '0;
    #3;
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset stall", 64'(stall), 64'd0);
    #9 rst_n = 1'b1;
    tick();

    run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, mul_lat(32'hFFFF_FFFF));
    run_op("mult_m7x3", F_MULT, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, mul_lat(32'h3));
    run_op("mult_min2", F_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, mul_lat(32'h8000_0000));
    run_op("multu_x0", F_MULTU, 32'h1234_5678, 32'h0, 32'h0, 32'h0, mul_lat(32'h0));
    run_op("multu_5x1", F_MULTU, 32'h5, 32'h1, 32'h0, 32'h5, mul_lat(32'h1));
    run_op("div_m7_2", F_DIV, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34);
    run_op("div_7_m2", F_DIV, 32'h7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34);
    run_op("divu_100_0", F_DIVU, 32'd100, 32'h0, 32'd100, 32'hFFFF_FFFF, 34);
    run_op("div_m7_0", F_DIV, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 34);
    run_op("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34);
    run_op("divu_big", F_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 32'h0FFF_FFFF, 34);

    // Flush ten cycles into RUN: abort, HI/LO untouched.
    start = 1'b1; funct = F_MULT; op_a = 32'h3; op_b = 32'h4000_0000;
    #1;
    for (int i = 0; i < 10; i++) tick();
    chk("flush_run busy", 64'(stall), 64'd1);
    flush = 1'b1; start = 1'b0;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_run stall", 64'(stall), 64'd0);
    chk("flush_run hi", 64'(hi), 64'(last_hi));
    chk("flush_run lo", 64'(lo), 64'(last_lo));
    watch_no_done("flush_run");

    // Flush and start together: nothing launches.
    start = 1'b1; funct = F_MULTU; op_a = 32'h9; op_b = 32'h9; flush = 1'b1;
    #1;
    chk("flush_start stall", 64'(stall), 64'd0);
    tick();
    start = 1'b0; flush = 1'b0;
    #1;
    chk("flush_start idle", 64'(stall), 64'd0);
    watch_no_done("flush_start");

    // Flush during DONE: the commit stands.
    start = 1'b1; funct = F_DIVU; op_a = 32'd9; op_b = 32'd4;
    #1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    chk("flush_done latency", 64'(cyc), 64'd34);
    start = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_done hi", 64'(hi), 64'd1);
    chk("flush_done lo", 64'(lo), 64'd2);
    chk("flush_done idle", 64'(stall), 64'd0);

    // MTLO then MULTU back-to-back.
    start = 1'b1; funct = F_MTLO; op_a = 32'h1234; op_b = 32'h0;
    #1;
    chk("mtlo stall", 64'(stall), 64'd0);
    tick();
    chk("mtlo lo", 64'(lo), 64'h1234);
    chk("mtlo hi_kept", 64'(hi), 64'd1);
    chk("mtlo done", 64'(done), 64'd0);
    run_op("multu_2x3", F_MULTU, 32'h2, 32'h3, 32'h0, 32'h6, mul_lat(32'h3));

    start = 1'b1; funct = F_MTHI; op_a = 32'hABCD; op_b = 32'h0;
    #1;
    chk("mthi stall", 64'(stall), 64'd0);
    tick();
    start = 1'b0;
    #1;
    chk("mthi hi", 64'(hi), 64'hABCD);
    chk("mthi lo_kept", 64'(lo), 64'h6);

    // Non-MDU funct is ignored.
    start = 1'b1; funct = 6'h20; op_a = 32'h55; op_b = 32'h66;
    #1;
    chk("nonmdu stall", 64'(stall), 64'd0);
    watch_no_done("nonmdu");
    start = 1'b0;
    #1;
    chk("nonmdu hi", 64'(hi), 64'hABCD);
    chk("nonmdu lo", 64'(lo), 64'h6);

    // Async reset in the middle of RUN.
    start = 1'b1; funct = F_MULTU; op_a = 32'h5; op_b = 32'h8000_0007;
    #1;
    for (int i = 0; i < 2; i++) tick();
    chk("rst_mid busy", 64'(stall), 64'd1);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid hi", 64'(hi), 64'd0);
    chk("rst_mid lo", 64'(lo), 64'd0);
    chk("rst_mid stall", 64'(stall), 64'd0);
    chk("rst_mid done", 64'(done), 64'd0);
    #1 rst_n = 1'b1;
    watch_no_done("rst_mid");

    run_op("after_rst", F_MULTU, 32'h7, 32'h6, 32'h0, 32'd42, mul_lat(32'h6));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
